// File: rtl/rr_arbiter8.sv
// Eight-client round-robin arbiter with a registered one-hot grant held until release.
// Define RR_ARB8_TIMEOUT_EN to add a watchdog that revokes grants held for TIMEOUT cycles.
module rr_arbiter8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] grant_id,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT out of range 2..255");
    end

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_id_q, grant_id_d;

    logic       any_req;
    logic       pick_found;
    logic [2:0] pick_id;
    logic [2:0] scan_idx;
    logic       release_now;
    logic       expire;

`ifdef RR_ARB8_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    assign expire = (cnt_q == 8'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    assign any_req     = |req;
    assign release_now = done || !req[grant_id_q];

    // Rotating scan: the first set bit at or after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 3'd0;
        scan_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
`ifdef RR_ARB8_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req && pick_found) begin
                    state_d    = ST_GRANT;
                    grant_d    = 8'd1 << pick_id;
                    grant_id_d = pick_id;
`ifdef RR_ARB8_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            default: begin
                // A real release on the expiry edge wins over the watchdog.
                if (release_now || expire) begin
                    state_d    = ST_IDLE;
                    grant_d    = 8'd0;
                    grant_id_d = 3'd0;
                    ptr_d      = grant_id_q + 3'd1;
`ifdef RR_ARB8_TIMEOUT_EN
                    cnt_d      = 8'd0;
                    timeout_d  = !release_now;
`endif
                end else begin
`ifdef RR_ARB8_TIMEOUT_EN
                    cnt_d      = cnt_q + 8'd1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            grant_q    <= 8'd0;
            grant_id_q <= 3'd0;
`ifdef RR_ARB8_TIMEOUT_EN
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
`ifdef RR_ARB8_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = grant_id_q;
`ifdef RR_ARB8_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a cycle model pushes expected outputs as
// stimulus is driven; they are popped and compared once the DUT has clocked.
module tb_rr_arbiter8;

    localparam int TIMEOUT = 4;
`ifdef RR_ARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    // reference model state
    bit m_busy = 0;
    int m_ptr = 0;
    int m_owner = 0;
    int m_cnt = 0;
    bit m_to = 0;

    rr_arbiter8 #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .done(done),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic dn);
        bit rel;
        bit exp_hit;
        m_to = 0;
        if (r) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!m_busy && rq[c]) begin
                    m_busy = 1; m_owner = c; m_cnt = 0;
                end
            end
        end else begin
            rel = dn || !rq[m_owner];
            exp_hit = TO_EN && (m_cnt == TIMEOUT - 1);
            if (rel || exp_hit) begin
                m_to = exp_hit && !rel;
                m_busy = 0;
                m_ptr = (m_owner + 1) % 8;
                m_owner = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic dn);
        exp_t e;
        exp_t got_e;
        reset = r; req = rq; done = dn;
        model_step(r, rq, dn);
        e.grant = m_busy ? (8'd1 << m_owner) : 8'd0;
        e.id    = m_busy ? 3'(m_owner) : 3'd0;
        e.valid = m_busy;
        e.to    = m_to;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            got_e = sb_q.pop_front();
            check("grant", grant, got_e.grant);
            check("grant_id", {5'd0, grant_id}, {5'd0, got_e.id});
            check("grant_valid", {7'd0, grant_valid}, {7'd0, got_e.valid});
            check("timeout", {7'd0, timeout}, {7'd0, got_e.to});
        end
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; done = 1'b0;
        step(1, 8'h00, 0);
        step(1, 8'hFF, 1);
        // idle with no requests, plus done while idle is ignored
        for (int i = 0; i < 10; i++) step(0, 8'h00, 0);
        step(0, 8'h00, 1);

        // single client, done three cycles after grant -> ptr=1
        step(0, 8'h01, 0);
        step(0, 8'h01, 0);
        step(0, 8'h01, 0);
        step(0, 8'h01, 1);
        step(0, 8'h00, 0);

        // all requesting, done every grant cycle: full rotation with wrap
        for (int i = 0; i < 20; i++) step(0, 8'hFF, (i % 2) == 1);
        step(0, 8'h00, 0);

        // serve client 4 (ptr->5), then 0x11 picks client 0 before client 4
        step(0, 8'h10, 0);
        step(0, 8'h10, 1);
        step(0, 8'h11, 0);
        step(0, 8'h11, 1);
        step(0, 8'h11, 0);
        step(0, 8'h11, 1);
        step(0, 8'h00, 0);

        // withdrawal release, then reset during a later grant
        step(0, 8'h04, 0);
        step(0, 8'h00, 0);
        step(0, 8'h0C, 0);
        step(0, 8'h0C, 0);
        step(1, 8'h0C, 1);
        step(0, 8'h0C, 0);
        step(0, 8'h0C, 1);
        step(0, 8'h00, 0);

        // simultaneous done and withdrawal
        step(0, 8'h20, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // long hold: watchdog revoke when enabled, indefinite hold otherwise
        for (int i = 0; i < 12; i++) step(0, 8'h08, 0);
        step(0, 8'h08, 1);
        // done coinciding with expiry
        step(0, 8'h00, 0);
        step(0, 8'h40, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 8'h40, 0);
        step(0, 8'h40, 1);
        step(0, 8'h00, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
